// File: rtl/gmii_rx_pkg.sv
// gmii_rx_pkg: shared types and constants for the GMII receive framer.
package gmii_rx_pkg;

  // Receive framer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Good-frame residue, expressed in normal (MSB-first) bit order
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // o_status bit positions
  localparam int unsigned STAT_CRC = 0;
  localparam int unsigned STAT_RX  = 1;
  localparam int unsigned STAT_LEN = 2;

  // Bytes held back so the trailing FCS never reaches the payload output
  localparam int unsigned DLY_DEPTH = 5;

  localparam logic [10:0] LEN_SAT = 11'h7FF;

  // Reverse the bit order of a 32-bit word
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    return {<<{v}};
  endfunction

endpackage

// File: rtl/gmii_rx_crc32_d8.sv
// crc32_d8: combinational byte-wise update of a reflected CRC-32 register.
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // Shift the byte in LSB first, folding in the reflected polynomial
  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx.sv
// gmii_rx: GMII receive framer. Strips preamble/SFD and the 4-byte FCS,
// emits payload with sof/eof, reports length/status and keeps frame counters.
// Optional feature macro: GMII_RX_CRC_EN (FCS check; crc_err tied 0 otherwise).
module gmii_rx
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_eth_rxdv,
  input  logic        i_eth_rxer,
  input  logic [7:0]  i_eth_rxd,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic [2:0]  o_status,
  output logic [10:0] o_len,
  output logic [15:0] o_frm_ok,
  output logic [15:0] o_frm_bad
);

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [2:0]  CNT_FULL = 3'(DLY_DEPTH);

  state_e state_q, state_d;

  // dly_q[0] is the newest byte, dly_q[DLY_DEPTH-1] the oldest
  logic [DLY_DEPTH-1:0][7:0] dly_q, dly_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic        rxerr_q, rxerr_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [2:0]  status_q, status_d;
  logic [10:0] olen_q, olen_d;
  logic [15:0] ok_q, ok_d;
  logic [15:0] bad_q, bad_d;

  logic        crc_err;
  logic [10:0] len_fin;
  logic [2:0]  stat_fin;

`ifdef GMII_RX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_nx;

  crc32_d8 u_crc32 (
    .crc_i  (crc_q),
    .data_i (i_eth_rxd),
    .crc_o  (crc_nx)
  );

  // CRC restarts on SFD and absorbs every byte after it, FCS included
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_PRE && i_eth_rxdv && i_eth_rxd == SFD) begin
      crc_d = CRC_INIT;
    end else if (state_q == ST_DATA && i_eth_rxdv) begin
      crc_d = crc_nx;
    end
  end

  // CRC register
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  // The register runs reflected, so flip it before matching the residue
  always_comb begin
    crc_err = (bitrev32(crc_q) != CRC_RESIDUE);
  end
`else
  // No FCS check in this build
  always_comb begin
    crc_err = 1'b0;
  end
`endif

  // Frame-end length and status, valid whenever a frame closes this cycle
  always_comb begin
    len_fin  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
    stat_fin = '0;
    stat_fin[STAT_LEN] = (len_fin < MIN_L) || (len_fin > MAX_L);
    stat_fin[STAT_RX]  = rxerr_q | i_eth_rxer;
    stat_fin[STAT_CRC] = crc_err;
  end

  // Next-state, delay line, and output staging
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rxerr_d  = rxerr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    status_d = status_q;
    olen_d   = olen_q;
    ok_d     = ok_q;
    bad_d    = bad_q;

    case (state_q)
      ST_IDLE: begin
        if (i_eth_rxdv) begin
          state_d = (i_eth_rxd == PREAMBLE) ? ST_PRE : ST_DROP;
        end
      end

      ST_PRE: begin
        if (!i_eth_rxdv) begin
          state_d = ST_IDLE;
        end else if (i_eth_rxd == SFD) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          len_d   = '0;
          rxerr_d = 1'b0;
        end else if (i_eth_rxd != PREAMBLE) begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (i_eth_rxdv) begin
          dly_d   = {dly_q[DLY_DEPTH-2:0], i_eth_rxd};
          rxerr_d = rxerr_q | i_eth_rxer;
          if (cnt_q == CNT_FULL) begin
            data_d  = dly_q[DLY_DEPTH-1];
            valid_d = 1'b1;
            sof_d   = (len_q == '0);
            len_d   = len_fin;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_FULL) begin
            // Oldest held byte is the last payload byte; the other four are FCS
            data_d   = dly_q[DLY_DEPTH-1];
            valid_d  = 1'b1;
            sof_d    = (len_q == '0);
            eof_d    = 1'b1;
            olen_d   = len_fin;
            status_d = stat_fin;
            if (stat_fin == '0) ok_d  = ok_q + 16'd1;
            else                bad_d = bad_q + 16'd1;
          end else begin
            bad_d = bad_q + 16'd1;
          end
        end
      end

      ST_DROP: begin
        if (!i_eth_rxdv) state_d = ST_IDLE;
      end

      default: state_d = ST_DROP;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_DROP;
      dly_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      rxerr_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      status_q <= '0;
      olen_q   <= '0;
      ok_q     <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rxerr_q  <= rxerr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      status_q <= status_d;
      olen_q   <= olen_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_sof     = sof_q;
  assign o_eof     = eof_q;
  assign o_status  = status_q;
  assign o_len     = olen_q;
  assign o_frm_ok  = ok_q;
  assign o_frm_bad = bad_q;

endmodule

// File: tb/tb_gmii_rx.sv
// tb_gmii_rx: directed, table-driven bench for gmii_rx.
module tb_gmii_rx;

`ifdef GMII_RX_CRC_EN
  localparam logic [2:0] CRC_EXP = 3'b001;
`else
  localparam logic [2:0] CRC_EXP = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxdv = 1'b0;
  logic        rxer = 1'b0;
  logic [7:0]  rxd = '0;
  logic [7:0]  o_data;
  logic        o_valid, o_sof, o_eof;
  logic [2:0]  o_status;
  logic [10:0] o_len;
  logic [15:0] o_frm_ok, o_frm_bad;

  always #4 clk = ~clk;

  gmii_rx #(.MIN_LEN(60), .MAX_LEN(1514)) dut (
    .i_clk_sys  (clk),
    .i_rst_n    (rst_n),
    .i_eth_rxdv (rxdv),
    .i_eth_rxer (rxer),
    .i_eth_rxd  (rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_status   (o_status),
    .o_len      (o_len),
    .o_frm_ok   (o_frm_ok),
    .o_frm_bad  (o_frm_bad)
  );

  typedef struct {
    string       name;
    int          n;
    int          corrupt;
    int          rxer_at;
    bit          runt;
    logic [10:0] exp_len;
    logic [2:0]  exp_status;
  } vec_t;

  vec_t tbl[9];

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  int sof_cnt = 0, eof_cnt = 0, seq_err = 0;
  logic [10:0] last_len = '0;
  logic [2:0]  last_status = '0;
  bit in_frame = 1'b0;
  int exp_ok = 0, exp_bad = 0, fid = 0;

  // Output monitor: collects payload and checks framing continuity
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (o_valid) begin
      if (o_sof) begin
        if (in_frame) seq_err++;
        in_frame = 1'b1;
        sof_cnt++;
      end else if (!in_frame) begin
        seq_err++;
      end
      got.push_back(o_data);
      if (o_eof) begin
        eof_cnt++;
        last_len    = o_len;
        last_status = o_status;
        in_frame    = 1'b0;
      end
    end else begin
      if (o_sof || o_eof) seq_err++;
      if (in_frame) seq_err++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rxdv = dv;
    rxer = er;
    rxd  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    sof_cnt = 0;
    eof_cnt = 0;
    seq_err = 0;
  endtask

  // Payload (corrupted after CRC if asked) followed by FCS, LSB byte first
  task automatic build_frame(input int n, input int corrupt, input bit runt);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  p;
    tx_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      p = 8'(i * 13 + fid * 7 + 1);
      c = crc_byte(c, p);
      if (i == corrupt) p = ~p;
      tx_q.push_back(p);
      if (!runt) exp_q.push_back(p);
    end
    fcs = ~c;
    if (!runt) begin
      for (int k = 0; k < 4; k++) tx_q.push_back(fcs[8*k +: 8]);
    end
    fid++;
  endtask

  task automatic send_frame(input int n, input int corrupt, input int rxer_at,
                            input bit runt, input int gap);
    build_frame(n, corrupt, runt);
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < tx_q.size(); i++) begin
      drive(1'b1, (i == rxer_at), tx_q[i]);
      if (!runt && i == 4) chk("latency no early valid", {31'h0, o_valid}, 32'd0);
      if (!runt && i == 5) begin
        chk("latency valid", {31'h0, o_valid}, 32'd1);
        chk("latency data", {24'h0, o_data}, {24'h0, tx_q[0]});
        chk("latency sof", {31'h0, o_sof}, 32'd1);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    if (!runt) begin
      chk("eof timing", {31'h0, o_eof}, 32'd1);
      chk("sof with eof", {31'h0, o_sof}, {31'h0, (n == 1)});
    end
    repeat (gap) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string nm, input int nbytes, input int nfrm,
                             input logic [10:0] elen, input logic [2:0] est);
    int mism;
    mism = 0;
    chk({nm, " bytes"}, got.size(), nbytes);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i] !== exp_q[i]) mism++;
    end
    chk({nm, " payload"}, mism, 0);
    chk({nm, " sof count"}, sof_cnt, nfrm);
    chk({nm, " eof count"}, eof_cnt, nfrm);
    if (nfrm > 0) begin
      chk({nm, " len"}, {21'h0, last_len}, {21'h0, elen});
      chk({nm, " status"}, {29'h0, last_status}, {29'h0, est});
    end
    chk({nm, " frm_ok"}, {16'h0, o_frm_ok}, exp_ok);
    chk({nm, " frm_bad"}, {16'h0, o_frm_bad}, exp_bad);
    chk({nm, " framing"}, seq_err, 0);
    clear_mon();
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{"good60",   60,   -1, -1, 1'b0, 11'd60,   3'b000};
    tbl[1] = '{"crc60",    60,   10, -1, 1'b0, 11'd60,   CRC_EXP};
    tbl[2] = '{"rxer60",   60,   -1, 20, 1'b0, 11'd60,   3'b010};
    tbl[3] = '{"runt3",    3,    -1, -1, 1'b1, 11'd0,    3'b000};
    tbl[4] = '{"short59",  59,   -1, -1, 1'b0, 11'd59,   3'b100};
    tbl[5] = '{"max1514",  1514, -1, -1, 1'b0, 11'd1514, 3'b000};
    tbl[6] = '{"long1515", 1515, -1, -1, 1'b0, 11'd1515, 3'b100};
    tbl[7] = '{"sat2100",  2100, -1, -1, 1'b0, 11'd2047, 3'b100};
    tbl[8] = '{"one_byte", 1,    -1, -1, 1'b0, 11'd1,    3'b100};

    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("reset frm_ok", {16'h0, o_frm_ok}, 32'd0);
    chk("reset frm_bad", {16'h0, o_frm_bad}, 32'd0);
    chk("reset datapath", {7'h0, o_valid, o_sof, o_eof, o_data, o_status, o_len}, 32'd0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    clear_mon();

    for (int t = 0; t < 9; t++) begin
      send_frame(tbl[t].n, tbl[t].corrupt, tbl[t].rxer_at, tbl[t].runt, 3);
      if (tbl[t].runt || tbl[t].exp_status != 3'b000) exp_bad++;
      else exp_ok++;
      check_frame(tbl[t].name, tbl[t].runt ? 0 : tbl[t].n, tbl[t].runt ? 0 : 1,
                  tbl[t].exp_len, tbl[t].exp_status);
    end

    // Back-to-back frames with a single idle cycle between them
    send_frame(64, -1, -1, 1'b0, 0);
    send_frame(64, -1, -1, 1'b0, 3);
    exp_ok += 2;
    check_frame("b2b", 128, 2, 11'd64, 3'b000);

    // Reset in mid-frame, released while rxdv is still high
    build_frame(60, -1, 1'b0);
    exp_q.delete();
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i <= 30; i++) drive(1'b1, 1'b0, tx_q[i]);
    rst_n = 1'b0;
    #1;
    chk("midreset frm_ok", {16'h0, o_frm_ok}, 32'd0);
    chk("midreset frm_bad", {16'h0, o_frm_bad}, 32'd0);
    chk("midreset datapath", {7'h0, o_valid, o_sof, o_eof, o_data, o_status, o_len}, 32'd0);
    clear_mon();
    for (int i = 31; i <= 33; i++) drive(1'b1, 1'b0, tx_q[i]);
    rst_n = 1'b1;
    for (int i = 34; i < tx_q.size(); i++) drive(1'b1, 1'b0, tx_q[i]);
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    exp_ok  = 0;
    exp_bad = 0;
    check_frame("rst drop", 0, 0, 11'd0, 3'b000);
    send_frame(60, -1, -1, 1'b0, 3);
    exp_ok = 1;
    check_frame("post rst", 60, 1, 11'd60, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
